// File: rtl/sram_ctrl_pkg.sv
// +----------------------------------------------------------------------------
// | sram_ctrl_pkg : shared state encoding and sizing helpers for the SRAM controller
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic int beats(input int word_w, input int dq_w);
      return word_w / dq_w;
   endfunction

   // Width of a counter holding 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_read_buffer.sv
// +----------------------------------------------------------------------------
// | sram_read_buffer : one-entry read cache {valid, word_idx, data} in front of the SRAM
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module sram_read_buffer #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  i_lookup_idx,
   output logic              o_hit,
   output logic [WORD_W-1:0] o_hit_data,
   input  logic              i_fill_en,
   input  logic [IDX_W-1:0]  i_fill_idx,
   input  logic [WORD_W-1:0] i_fill_data,
   input  logic              i_upd_en,
   input  logic [IDX_W-1:0]  i_upd_idx,
   input  logic [WORD_W-1:0] i_upd_data
);

   logic              r_valid;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_data  <= '0;
      end else if (i_fill_en) begin
         r_valid <= 1'b1;
         r_idx   <= i_fill_idx;
         r_data  <= i_fill_data;
      end else if (i_upd_en && r_valid && (r_idx == i_upd_idx)) begin
         r_data  <= i_upd_data;
      end
   end

   assign o_hit      = r_valid && (r_idx == i_lookup_idx);
   assign o_hit_data = r_data;

endmodule

`default_nettype wire

// File: rtl/sram_burst_controller.sv
// +----------------------------------------------------------------------------
// | sram_burst_controller : serves one pipeline word as BEATS narrow SRAM beats with wait states
// | Optional read buffer enabled by SRAM_READ_BUFFER_EN.  Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module sram_burst_controller
   import sram_ctrl_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int DQ_W        = 16,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 4,
   parameter int BASE_ADDR   = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            addr,
   input  logic [WORD_W-1:0]      wdata,
   output logic [WORD_W-1:0]      rdata,
   output logic                   ready,
   inout  wire  [DQ_W-1:0]        SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N
);

   localparam int                  c_beats     = beats(WORD_W, DQ_W);
   localparam int                  c_beat_w    = cnt_w(c_beats);
   localparam int                  c_wait_w    = cnt_w(WAIT_CYCLES + 1);
   localparam int                  c_byte_sh   = $clog2(WORD_W / 8);
   localparam logic [31:0]         c_base      = 32'(BASE_ADDR);
   localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
   localparam logic [c_wait_w-1:0] c_last_wait = c_wait_w'(WAIT_CYCLES);

   state_t              r_state, w_state_nxt;
   logic                r_op_wr;
   logic [31:0]         r_word_idx;
   logic [WORD_W-1:0]   r_wdata, r_asm, r_rdata, w_asm_nxt;
   logic [c_beat_w-1:0] r_beat;
   logic [c_wait_w-1:0] r_wait;
   logic                w_req, w_rd_only, w_beat_end, w_last, w_hit, w_drive;
   logic [31:0]         w_req_idx;
   logic [WORD_W-1:0]   w_hit_data;
   logic [DQ_W-1:0]     w_dq_out;

   assign w_req      = rd_en | wr_en;
   assign w_rd_only  = rd_en & ~wr_en;
   assign w_req_idx  = (addr - c_base) >> c_byte_sh;
   assign w_beat_end = (r_wait == c_last_wait);
   assign w_last     = w_beat_end && (r_beat == c_last_beat);
   assign w_drive    = (r_state == ACCESS) && r_op_wr;

`ifdef SRAM_READ_BUFFER_EN
   sram_read_buffer #(
      .WORD_W (WORD_W),
      .IDX_W  (32)
   ) u_read_buffer (
      .clk          (clk),
      .rst          (rst),
      .i_lookup_idx (w_req_idx),
      .o_hit        (w_hit),
      .o_hit_data   (w_hit_data),
      .i_fill_en    ((r_state == ACCESS) && !r_op_wr && w_last),
      .i_fill_idx   (r_word_idx),
      .i_fill_data  (w_asm_nxt),
      .i_upd_en     ((r_state == ACCESS) && r_op_wr && w_last),
      .i_upd_idx    (r_word_idx),
      .i_upd_data   (r_wdata)
   );
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = '0;
`endif

   // Beat slices: beat 0 is the least-significant DQ_W bits
   always_comb begin
      w_asm_nxt                        = r_asm;
      w_asm_nxt[r_beat*DQ_W +: DQ_W]   = SRAM_DQ;
      w_dq_out                         = r_wdata[r_beat*DQ_W +: DQ_W];
   end

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      case (r_state)
         IDLE: begin
            ready = ~w_req;
            if (w_req)
               w_state_nxt = (w_rd_only && w_hit) ? DONE : ACCESS;
         end
         ACCESS: begin
            if (w_last)
               w_state_nxt = DONE;
         end
         DONE: begin
            ready       = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_op_wr    <= 1'b0;
         r_word_idx <= '0;
         r_wdata    <= '0;
         r_asm      <= '0;
         r_rdata    <= '0;
         r_beat     <= '0;
         r_wait     <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_op_wr <= wr_en;
                  r_beat  <= '0;
                  r_wait  <= '0;
                  if (w_rd_only && w_hit) begin
                     r_rdata <= w_hit_data;
                  end else begin
                     r_word_idx <= w_req_idx;
                     r_wdata    <= wdata;
                  end
               end
            end
            ACCESS: begin
               if (!r_op_wr && w_beat_end)
                  r_asm <= w_asm_nxt;
               if (!r_op_wr && w_last)
                  r_rdata <= w_asm_nxt;
               if (w_beat_end) begin
                  r_wait <= '0;
                  r_beat <= w_last ? '0 : r_beat + c_beat_w'(1);
               end else begin
                  r_wait <= r_wait + c_wait_w'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Last cycle of each write beat keeps WE_N high for bus turnaround
   assign SRAM_WE_N = ~(w_drive && !w_beat_end);
   assign SRAM_DQ   = w_drive ? w_dq_out : {DQ_W{1'bz}};
   assign SRAM_ADDR = SRAM_ADDR_W'(r_word_idx * 32'(c_beats) + 32'(r_beat));
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign rdata     = r_rdata;

endmodule

`default_nettype wire
